// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: captures a 16-bit word on a VALID rising edge and
// scans it as hex digits with a blanking guard cycle per slot and optional leading-zero blanking.
module sseg_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic        VALID,
    output logic [3:0]  ANODES,
    output logic [6:0]  CATHODES,
    output logic        LOADED
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [6:0] Dash = 7'b0111111;

    logic            valid_q;
    logic [15:0]     disp_q, disp_d;
    logic            loaded_q, loaded_d;
    logic [CntW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      anodes_q, anodes_d;
    logic [6:0]      cathodes_q, cathodes_d;

    logic            load;
    logic [3:0]      nibble;
    logic [15:0]     upper;
    logic            upper_zero;
    logic [3:0]      digit_en;
    logic [6:0]      digit_code;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] code;
        unique case (n)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            4'hF: code = 7'b0001110;
        endcase
        return code;
    endfunction

    always_comb begin
        load     = VALID & ~valid_q;
        disp_d   = load ? VALUE : disp_q;
        loaded_d = loaded_q | load;

        if (scan_cnt_q == CntMax) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            idx_d      = idx_q;
        end
    end

    // Display decode works on pre-edge state; the result lands in the output registers.
    always_comb begin
        nibble     = disp_q[{idx_q, 2'b00} +: 4];
        upper      = disp_q >> {idx_q, 2'b00};
        upper_zero = (idx_q != 2'd0) && (upper == 16'h0000);
        digit_en   = ~(4'b0001 << idx_q);
        digit_code = loaded_q ? hex_font(nibble) : Dash;

        anodes_d   = digit_en;
        cathodes_d = digit_code;
        if (scan_cnt_q == '0) begin
            anodes_d = 4'b1111;
        end else if (!loaded_q) begin
            cathodes_d = Dash;
        end else if (BLANK_LZ && upper_zero) begin
            anodes_d = 4'b1111;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q    <= 1'b0;
            disp_q     <= 16'h0000;
            loaded_q   <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            anodes_q   <= 4'b1111;
            cathodes_q <= 7'b1111111;
        end else begin
            valid_q    <= VALID;
            disp_q     <= disp_d;
            loaded_q   <= loaded_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            cathodes_q <= cathodes_d;
        end
    end

    assign ANODES   = anodes_q;
    assign CATHODES = cathodes_q;
    assign LOADED   = loaded_q;

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Four-digit multiplexed seven-segment display driver that sits directly downstream of the PUF stage. It captures a 16-bit word, `{challenge, response}`, on the rising edge of a level-type valid/done signal. It then scans the word as four hex digits onto the board's shared-cathode display, with anti-ghosting guard cycles and optional leading-zero blanking. Until the first capture, every digit shows a dash.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot. Minimum 2. At 100 MHz the default gives 1 ms per digit.
- `BLANK_LZ`, default 1: 1 blanks leading zero digits 3..1; 0 shows all four digits.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `VALUE`  in  16  word to display; `VALUE[3:0]` is digit 0, the rightmost.
- `VALID`  in  1  level signal; a low-to-high transition requests capture of `VALUE`.
- `ANODES`  out  4  digit enables, active-low; `ANODES[i]` drives digit i.
- `CATHODES`  out  7  segments, active-low, ordered `{g,f,e,d,c,b,a}` from bit 6 to bit 0.
- `LOADED`  out  1  high once any value has been captured since reset.

## Operation
- **Edge detect:** `valid_q` <= `VALID` every cycle. `load` = `VALID & ~valid_q`.
  - On `load`: `disp_reg` <= `VALUE` and `LOADED` <= 1.
  - Holding `VALID` high captures once only. A new capture needs `VALID` to go low, then high again.
- **Scan counter:** `scan_cnt` counts 0..`SCAN_DIV`-1 and wraps to 0.
  - On wrap, `idx` (2 bits) increments 0→1→2→3→0.
- **Output registers:** each cycle, `ANODES` and `CATHODES` are registered from the pre-edge values of `scan_cnt`, `idx`, `disp_reg` and `LOADED`, using the priority below (first match wins):
  - `scan_cnt`==0 (guard cycle): `ANODES`=4'b1111. `CATHODES` holds the code for the current digit.
  - `LOADED`==0: assert only `ANODES[idx]`; `CATHODES`=7'b0111111 (dash).
  - `BLANK_LZ`==1 and `idx`≥1 and all of `disp_reg` nibbles idx..3 are zero: `ANODES`=4'b1111 (digit blanked).
  - Otherwise: assert only `ANODES[idx]`; `CATHODES` = hex font of nibble `idx` of `disp_reg`.
- Digit 0 is never blanked. A value of 0 shows "0" on digit 0.
- **Hex font:** standard 0-F, active-low. Required codes:
  - 0=1000000
  - 5=0010010
  - 7=1111000
  - 8=0000000
  - A=0001000
  - b=0000011
  - C=1000110
  - d=0100001
  - E=0000110
  - F=0001110

## Timing
- **Reset** (`RST_N` low, takes effect immediately):
  - `ANODES`=4'b1111, `CATHODES`=7'b1111111, `LOADED`=0.
  - `scan_cnt`=0, `idx`=0, `valid_q`=0, `disp_reg`=0.
- **After reset release:**
  - Edge 1: guard cycle, `ANODES`=1111.
  - Edge 2: `ANODES`=1110 with a dash.
  - Each digit slot is `SCAN_DIV` cycles: 1 guard cycle plus `SCAN_DIV`-1 lit cycles.
- **VALID latency:**
  - `VALID` is sampled high at edge E, with `valid_q` low.
  - `disp_reg` and `LOADED` update at edge E.
  - The new value first appears on the outputs at edge E+1, provided that cycle is not a guard cycle.
- **VALID high during reset release:** if `VALID` is high at the first edge after release, it counts as a rising edge and is captured.
- **Load coinciding with scan wrap:**
  - Both updates happen at the same edge.
  - The following guard cycle is unaffected.
  - The next lit digit shows the new value.
- **Reset mid-scan:** outputs are forced to all-off asynchronously. After release, the display returns to dashes starting at digit 0.
- **Overflow:** none possible. `scan_cnt` is sized to ceil(log2(`SCAN_DIV`)) bits and `idx` wraps naturally.

## Test plan
Benches use `SCAN_DIV`=4 and run at 100 MHz.

1. **Reset and dash scan:** hold `RST_N` low for 5 cycles, then release.
   - During reset: 1111 / 1111111 / `LOADED`=0.
   - Then `ANODES` sequence per 4-cycle slot: 1111 for 1 cycle, then 1110 for 3 cycles; then 1111, then 1101 for 3 cycles; continuing through 1011 and 0111.
   - `CATHODES`=0111111 on every lit cycle.
2. **Full word:** `VALUE`=16'hA580, 1-cycle `VALID` pulse, `BLANK_LZ`=1.
   - `LOADED`=1 one edge later.
   - Lit digits 0..3 show 1000000, 0000000, 0010010, 0001000.
3. **Leading-zero blanking:** `VALUE`=16'h0007 with `BLANK_LZ`=1.
   - Only `ANODES`=1110 is ever asserted, with 1111000; slots 1-3 read 1111.
   - Repeat with `BLANK_LZ`=0: digits 1-3 show 1000000.
   - `VALUE`=0 with `BLANK_LZ`=1: digit 0 shows 1000000.
4. **Level VALID:**
   - Hold `VALID` high for 50 cycles while `VALUE` changes from 16'h1234 to 16'hFFFF: display stays 1234.
   - Drop `VALID` low for 1 cycle, then raise it: display becomes FFFF (0001110 on all digits).
5. **Async reset mid-scan:** assert `RST_N` low between clock edges while digit 2 is lit.
   - Outputs go to 1111/1111111 before the next edge.
   - `LOADED`=0.
   - After release, dashes resume from digit 0.
6. **Load at wrap:** pulse `VALID` (`VALUE`=16'hBEEF) on the cycle where `scan_cnt`=3 and `idx`=0.
   - The next edge is a guard cycle.
   - Digit 1 then shows E (0000110).
   - Digit 0 shows F (0001110) on its next slot.
